shop_ctrl_v: RTL and testbench
==============================

Name: shop_ctrl_v

Overview:
- Parametrised successor to the single-user shop command block.
- Token-driven command FSM in front of two tables:
  - a user table, with MAX_USERS entries (name, password, valid); slot 0 is the fixed admin.
  - an item inventory, with MAX_ITEMS entries (name, stock, valid).
- Each i_rdy rising edge consumes one ASCII token on i_a plus a quantity on i_u, and produces one registered ASCII response on o_a with an o_vld strobe.
- Sits between the host/UART string front-end and the display formatter.

Parameters:
- I_A_NUM_ASCII_CHARS, 7, input token width in chars; must fit the longest command key.
- O_A_NUM_ASCII_CHARS, 9, response width in chars.
- I_U_NUM_BITS, 4, quantity width.
- MAX_USERS, 5, user slots, including admin in slot 0.
- MAX_ITEMS, 8, inventory slots.
- STOCK_NUM_BITS, 8, per-item stock counter width.
- ADMIN_USERNAME, "Adm", admin name loaded at reset.
- ADMIN_PASSWORD, "123", admin password loaded at reset.
- IDLE_CYCLES, 1000, idle-logout threshold; used only with the optional feature.

Ports:
- i_clk  in  1  sole clock; rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_rdy  in  1  token strobe; rising-edge detected internally.
- i_u  in  I_U_NUM_BITS  unsigned quantity for AddItem/Buy.
- i_a  in  I_A_NUM_ASCII_CHARS*8  ASCII token, right-aligned, zero-padded.
- o_a  out  O_A_NUM_ASCII_CHARS*8  ASCII response, right-aligned, zero-padded.
- o_vld  out  1  one-cycle pulse when o_a updates.
- o_user  out  clog2(MAX_USERS)+1  MSB = logged-in flag; low bits = current user slot.
- o_busy  out  1  high while the FSM is in any state other than S_CMD.

Behaviour:
- Reset (i_reset=0, asynchronous):
  - Outputs: o_a="Cmd?", o_vld=0, o_user=0, o_busy=0.
  - State: S_CMD.
  - User table: all valid bits cleared, then slot 0 = ADMIN_USERNAME/ADMIN_PASSWORD, valid.
  - Inventory: all entries cleared.
  - rdy_q cleared.
  - Reset asserted mid-transaction discards the pending transaction.
- Handshake:
  - tok = i_rdy & ~rdy_q, with rdy_q registered.
  - A held-high i_rdy produces one token only.
  - The response is registered one cycle after the tok cycle: o_a and o_vld=1 update at that edge; o_vld clears the next cycle.
  - Token-to-token minimum spacing is 2 cycles; closer tokens are still processed one per edge.
- Name match: full-width equality of i_a against valid entries only. Invalid slots never match.
- Permission classes:
  - Logged out: only Login is allowed.
  - Logged in, any user: Logout, Buy.
  - Admin only: AddUsr, DelUsr, AddItem, DelItem.
  - Login while logged in, or a disallowed key: "InvalPerm", stay in S_CMD.
  - Unknown key: "InvalCmd".
- FSM states and transitions:
  - S_CMD: decode key.
    - Login: S_USER, "Username?".
    - Logout: clear user, "Bye".
    - AddUsr: if no free slot, "Full"; else S_NEWU, "Username?".
    - DelUsr: S_DELU, "Username?".
    - AddItem: S_ADDI, "Item?".
    - DelItem: S_DELI, "Item?".
    - Buy: S_BUY, "Item?".
  - S_USER: on hit, latch index, go to S_PASS, "Password?"; on miss, "InvalUsr", go to S_CMD.
  - S_PASS: on match with the latched slot, set o_user, "Welcome"; else "InvalPwd". Either way go to S_CMD.
  - S_NEWU: duplicate name gives "Exists", go to S_CMD; otherwise latch the name, go to S_NEWP, "Password?".
  - S_NEWP: write the lowest free slot, "Done", go to S_CMD.
  - S_DELU: slot 0 gives "InvalPerm"; miss gives "InvalUsr"; else clear valid, "Done". All go to S_CMD.
  - S_ADDI:
    - Existing item: stock = min(stock+i_u, 2^STOCK_NUM_BITS-1), saturating.
    - New item: allocate the lowest free slot with stock=i_u; if no free slot, "Full".
    - "Done" on success; go to S_CMD.
  - S_DELI: on hit, clear the entry, "Done"; on miss, "InvalItem". Go to S_CMD.
  - S_BUY:
    - Miss: "InvalItem".
    - i_u=0 or i_u>stock: "NoStock", stock unchanged.
    - Otherwise stock -= i_u, "Done".
    - Go to S_CMD.
- Zero stock does not free an item slot; only DelItem frees it.

Optional Feature:
- Macro: SHOP_IDLE_LOGOUT_EN.
- Defined:
  - A counter counts cycles with no tok while the FSM is logged in or not in S_CMD.
  - At IDLE_CYCLES the block clears the user, forces S_CMD and emits "Timeout" with o_vld.
  - The counter reloads on every tok.
  - A tok arriving in the expiry cycle wins: it is processed and no timeout fires.
- Undefined: no counter, no timeout; IDLE_CYCLES is unused.

Decomposition:
- Package shop_pkg:
  - CMD_KEY__* constants.
  - RSP__* response strings.
  - State encoding S_*.
  - Permission-class constants.
- Sub-module shop_cam_v, instantiated twice (users, items):
  - Parameters: depth and key width.
  - Outputs: hit, hit index and first-free index (lowest wins), plus a full flag.
  - Fully combinational.

Test Plan:
- Reset, then token "sdfsdf": o_a="InvalCmd" one cycle after tok, with o_vld a single pulse. Next, token AddItem while logged out: "InvalPerm".
- Login, "Adm", "123": responses "Username?", "Password?", "Welcome"; o_user = 1_000.
- As admin, AddItem "Pen" with i_u=15 twice, at STOCK_NUM_BITS=4: responses "Done", "Done"; stock saturates at 15.
- As a user, Buy "Pen" i_u=0 gives "NoStock"; i_u=5 gives "Done" with stock 10; Buy "Cup" gives "InvalItem".
- Fill all MAX_USERS slots, then AddUsr: "Full". DelUsr "Adm": "InvalPerm".
- With SHOP_IDLE_LOGOUT_EN and IDLE_CYCLES=20: log in, then idle 20 cycles. Expect "Timeout" and o_user=0. Also pulse reset low while in S_PASS: state S_CMD and o_a="Cmd?" immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/shop_pkg.sv
// Shared constants for the shop command controller: command keys, response strings,
// FSM state encoding and permission classes.
package shop_pkg;

    localparam int unsigned KEY_W = 56;
    localparam int unsigned RSP_W = 72;

    localparam logic [KEY_W-1:0] CMD_KEY__LOGIN   = KEY_W'("Login");
    localparam logic [KEY_W-1:0] CMD_KEY__LOGOUT  = KEY_W'("Logout");
    localparam logic [KEY_W-1:0] CMD_KEY__ADDUSR  = KEY_W'("AddUsr");
    localparam logic [KEY_W-1:0] CMD_KEY__DELUSR  = KEY_W'("DelUsr");
    localparam logic [KEY_W-1:0] CMD_KEY__ADDITEM = KEY_W'("AddItem");
    localparam logic [KEY_W-1:0] CMD_KEY__DELITEM = KEY_W'("DelItem");
    localparam logic [KEY_W-1:0] CMD_KEY__BUY     = KEY_W'("Buy");

    localparam logic [RSP_W-1:0] RSP__CMD       = RSP_W'("Cmd?");
    localparam logic [RSP_W-1:0] RSP__USERNAME  = RSP_W'("Username?");
    localparam logic [RSP_W-1:0] RSP__PASSWORD  = RSP_W'("Password?");
    localparam logic [RSP_W-1:0] RSP__ITEM      = RSP_W'("Item?");
    localparam logic [RSP_W-1:0] RSP__WELCOME   = RSP_W'("Welcome");
    localparam logic [RSP_W-1:0] RSP__BYE       = RSP_W'("Bye");
    localparam logic [RSP_W-1:0] RSP__DONE      = RSP_W'("Done");
    localparam logic [RSP_W-1:0] RSP__FULL      = RSP_W'("Full");
    localparam logic [RSP_W-1:0] RSP__EXISTS    = RSP_W'("Exists");
    localparam logic [RSP_W-1:0] RSP__NOSTOCK   = RSP_W'("NoStock");
    localparam logic [RSP_W-1:0] RSP__INVALCMD  = RSP_W'("InvalCmd");
    localparam logic [RSP_W-1:0] RSP__INVALPERM = RSP_W'("InvalPerm");
    localparam logic [RSP_W-1:0] RSP__INVALUSR  = RSP_W'("InvalUsr");
    localparam logic [RSP_W-1:0] RSP__INVALPWD  = RSP_W'("InvalPwd");
    localparam logic [RSP_W-1:0] RSP__INVALITEM = RSP_W'("InvalItem");
    localparam logic [RSP_W-1:0] RSP__TIMEOUT   = RSP_W'("Timeout");

    typedef enum logic [3:0] {
        S_CMD, S_USER, S_PASS, S_NEWU, S_NEWP, S_DELU, S_ADDI, S_DELI, S_BUY
    } state_e;

    typedef enum logic [2:0] {
        C_NONE, C_LOGIN, C_LOGOUT, C_ADDUSR, C_DELUSR, C_ADDITEM, C_DELITEM, C_BUY
    } cmd_e;

    typedef enum logic [1:0] {
        PERM_BAD, PERM_OUT, PERM_USER, PERM_ADMIN
    } perm_e;

    // Who may issue a decoded command.
    function automatic perm_e perm_of(input cmd_e c);
        case (c)
            C_LOGIN:                                    return PERM_OUT;
            C_LOGOUT, C_BUY:                            return PERM_USER;
            C_ADDUSR, C_DELUSR, C_ADDITEM, C_DELITEM:   return PERM_ADMIN;
            default:                                    return PERM_BAD;
        endcase
    endfunction

endpackage

// File: rtl/shop_cam_v.sv
// Combinational lookup over a small table: exact-match hit, lowest matching index,
// lowest free index and full flag.
module shop_cam_v
    import shop_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 56,
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic [WIDTH-1:0] keys [DEPTH],
    input  logic [DEPTH-1:0] valid,
    input  logic [WIDTH-1:0] key,
    output logic             hit,
    output logic [IDX_W-1:0] hit_idx,
    output logic [IDX_W-1:0] free_idx,
    output logic             full
);

    // Scan downwards so the lowest index is the last one written.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free_idx = '0;
        full     = 1'b1;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (valid[i] && keys[i] == key) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!valid[i]) begin
                full     = 1'b0;
                free_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/shop_ctrl_v.sv
// Token-driven shop command FSM over a user table and an item inventory.
// Optional idle logout is enabled with SHOP_IDLE_LOGOUT_EN.
module shop_ctrl_v
    import shop_pkg::*;
#(
    parameter int unsigned I_A_NUM_ASCII_CHARS = 7,
    parameter int unsigned O_A_NUM_ASCII_CHARS = 9,
    parameter int unsigned I_U_NUM_BITS        = 4,
    parameter int unsigned MAX_USERS           = 5,
    parameter int unsigned MAX_ITEMS           = 8,
    parameter int unsigned STOCK_NUM_BITS      = 8,
    parameter logic [8*I_A_NUM_ASCII_CHARS-1:0] ADMIN_USERNAME = (8*I_A_NUM_ASCII_CHARS)'("Adm"),
    parameter logic [8*I_A_NUM_ASCII_CHARS-1:0] ADMIN_PASSWORD = (8*I_A_NUM_ASCII_CHARS)'("123"),
    parameter int unsigned IDLE_CYCLES         = 1000
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic                             i_rdy,
    input  logic [I_U_NUM_BITS-1:0]          i_u,
    input  logic [8*I_A_NUM_ASCII_CHARS-1:0] i_a,
    output logic [8*O_A_NUM_ASCII_CHARS-1:0] o_a,
    output logic                             o_vld,
    output logic [$clog2(MAX_USERS):0]       o_user,
    output logic                             o_busy
);

    localparam int unsigned A_W    = 8 * I_A_NUM_ASCII_CHARS;
    localparam int unsigned R_W    = 8 * O_A_NUM_ASCII_CHARS;
    localparam int unsigned UIDX_W = $clog2(MAX_USERS);
    localparam int unsigned IIDX_W = $clog2(MAX_ITEMS);
    localparam int unsigned S_W    = STOCK_NUM_BITS;
    localparam int unsigned SUM_W  = ((S_W > I_U_NUM_BITS) ? S_W : I_U_NUM_BITS) + 1;
    localparam logic [S_W-1:0] STOCK_MAX = '1;

    if (MAX_USERS < 2 || MAX_ITEMS < 2 || I_A_NUM_ASCII_CHARS < 7 || IDLE_CYCLES < 1) begin : g_bad_cfg
        $error("shop_ctrl_v: unsupported parameter set");
    end

    function automatic logic [S_W-1:0] sat_add(input logic [S_W-1:0] s, input logic [I_U_NUM_BITS-1:0] q);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(s) + SUM_W'(q);
        return (sum > SUM_W'(STOCK_MAX)) ? STOCK_MAX : S_W'(sum);
    endfunction

    state_e              state, state_n;
    logic                rdy_q, tok;
    logic [R_W-1:0]      rsp_n;
    logic                vld_n, busy_n;
    logic [UIDX_W:0]     user_n;
    logic [UIDX_W-1:0]   sel_q, sel_n;
    logic [A_W-1:0]      newname_q, newname_n;
    logic                logged, is_admin, allowed;
    cmd_e                cmd;
    perm_e               perm;

    logic [A_W-1:0]       user_name [MAX_USERS];
    logic [A_W-1:0]       user_pass [MAX_USERS];
    logic [MAX_USERS-1:0] user_vld;
    logic [A_W-1:0]       item_name  [MAX_ITEMS];
    logic [S_W-1:0]       item_stock [MAX_ITEMS];
    logic [MAX_ITEMS-1:0] item_vld;

    logic                u_hit, u_full, it_hit, it_full;
    logic [UIDX_W-1:0]   u_hit_idx, u_free_idx;
    logic [IIDX_W-1:0]   it_hit_idx, it_free_idx;

    logic                u_we, u_clr, it_we, it_clr;
    logic [UIDX_W-1:0]   u_cidx;
    logic [IIDX_W-1:0]   it_idx;
    logic [S_W-1:0]      it_wstock;

    assign tok      = i_rdy & ~rdy_q;
    assign logged   = o_user[UIDX_W];
    assign is_admin = logged && (o_user[UIDX_W-1:0] == '0);

    shop_cam_v #(.DEPTH(MAX_USERS), .WIDTH(A_W)) u_user_cam (
        .keys(user_name), .valid(user_vld), .key(i_a),
        .hit(u_hit), .hit_idx(u_hit_idx), .free_idx(u_free_idx), .full(u_full)
    );

    shop_cam_v #(.DEPTH(MAX_ITEMS), .WIDTH(A_W)) u_item_cam (
        .keys(item_name), .valid(item_vld), .key(i_a),
        .hit(it_hit), .hit_idx(it_hit_idx), .free_idx(it_free_idx), .full(it_full)
    );

    // Command key decode.
    always_comb begin
        cmd = C_NONE;
        if      (i_a == A_W'(CMD_KEY__LOGIN))   cmd = C_LOGIN;
        else if (i_a == A_W'(CMD_KEY__LOGOUT))  cmd = C_LOGOUT;
        else if (i_a == A_W'(CMD_KEY__ADDUSR))  cmd = C_ADDUSR;
        else if (i_a == A_W'(CMD_KEY__DELUSR))  cmd = C_DELUSR;
        else if (i_a == A_W'(CMD_KEY__ADDITEM)) cmd = C_ADDITEM;
        else if (i_a == A_W'(CMD_KEY__DELITEM)) cmd = C_DELITEM;
        else if (i_a == A_W'(CMD_KEY__BUY))     cmd = C_BUY;
        perm    = perm_of(cmd);
        allowed = (perm == PERM_OUT && !logged) || (perm == PERM_USER && logged)
               || (perm == PERM_ADMIN && is_admin);
    end

`ifdef SHOP_IDLE_LOGOUT_EN
    localparam int unsigned CNT_W = $clog2(IDLE_CYCLES + 1);
    logic [CNT_W-1:0] idle_q, idle_n;
    logic             expire;

    // Idle counter runs only while a session or a transaction is open.
    always_comb begin
        idle_n = '0;
        expire = 1'b0;
        if (!tok && (logged || state != S_CMD)) begin
            if (idle_q == CNT_W'(IDLE_CYCLES - 1)) expire = 1'b1;
            else                                   idle_n = idle_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) idle_q <= '0;
        else          idle_q <= idle_n;
    end
`endif

    // Next state, registered outputs and table write strobes.
    always_comb begin
        state_n   = state;
        rsp_n     = o_a;
        vld_n     = 1'b0;
        user_n    = o_user;
        sel_n     = sel_q;
        newname_n = newname_q;
        u_we      = 1'b0;
        u_clr     = 1'b0;
        u_cidx    = u_hit_idx;
        it_we     = 1'b0;
        it_clr    = 1'b0;
        it_idx    = it_hit_idx;
        it_wstock = '0;
        if (tok) begin
            vld_n   = 1'b1;
            state_n = S_CMD;
            case (state)
                S_CMD: begin
                    if (perm == PERM_BAD)  rsp_n = R_W'(RSP__INVALCMD);
                    else if (!allowed)     rsp_n = R_W'(RSP__INVALPERM);
                    else begin
                        case (cmd)
                            C_LOGIN:   begin state_n = S_USER; rsp_n = R_W'(RSP__USERNAME); end
                            C_LOGOUT:  begin user_n = '0; rsp_n = R_W'(RSP__BYE); end
                            C_ADDUSR: begin
                                if (u_full) rsp_n = R_W'(RSP__FULL);
                                else begin state_n = S_NEWU; rsp_n = R_W'(RSP__USERNAME); end
                            end
                            C_DELUSR:  begin state_n = S_DELU; rsp_n = R_W'(RSP__USERNAME); end
                            C_ADDITEM: begin state_n = S_ADDI; rsp_n = R_W'(RSP__ITEM); end
                            C_DELITEM: begin state_n = S_DELI; rsp_n = R_W'(RSP__ITEM); end
                            C_BUY:     begin state_n = S_BUY;  rsp_n = R_W'(RSP__ITEM); end
                            default:   rsp_n = R_W'(RSP__INVALCMD);
                        endcase
                    end
                end
                S_USER: begin
                    if (u_hit) begin
                        sel_n   = u_hit_idx;
                        state_n = S_PASS;
                        rsp_n   = R_W'(RSP__PASSWORD);
                    end else rsp_n = R_W'(RSP__INVALUSR);
                end
                S_PASS: begin
                    if (user_vld[sel_q] && i_a == user_pass[sel_q]) begin
                        user_n = {1'b1, sel_q};
                        rsp_n  = R_W'(RSP__WELCOME);
                    end else rsp_n = R_W'(RSP__INVALPWD);
                end
                S_NEWU: begin
                    if (u_hit) rsp_n = R_W'(RSP__EXISTS);
                    else begin
                        newname_n = i_a;
                        state_n   = S_NEWP;
                        rsp_n     = R_W'(RSP__PASSWORD);
                    end
                end
                S_NEWP: begin
                    if (u_full) rsp_n = R_W'(RSP__FULL);
                    else begin u_we = 1'b1; rsp_n = R_W'(RSP__DONE); end
                end
                S_DELU: begin
                    if (!u_hit)                 rsp_n = R_W'(RSP__INVALUSR);
                    else if (u_hit_idx == '0)   rsp_n = R_W'(RSP__INVALPERM);
                    else begin u_clr = 1'b1; rsp_n = R_W'(RSP__DONE); end
                end
                S_ADDI: begin
                    if (it_hit) begin
                        it_we     = 1'b1;
                        it_wstock = sat_add(item_stock[it_hit_idx], i_u);
                        rsp_n     = R_W'(RSP__DONE);
                    end else if (it_full) rsp_n = R_W'(RSP__FULL);
                    else begin
                        it_we     = 1'b1;
                        it_idx    = it_free_idx;
                        it_wstock = sat_add('0, i_u);
                        rsp_n     = R_W'(RSP__DONE);
                    end
                end
                S_DELI: begin
                    if (it_hit) begin it_clr = 1'b1; rsp_n = R_W'(RSP__DONE); end
                    else rsp_n = R_W'(RSP__INVALITEM);
                end
                S_BUY: begin
                    if (!it_hit) rsp_n = R_W'(RSP__INVALITEM);
                    else if (i_u == '0 || SUM_W'(i_u) > SUM_W'(item_stock[it_hit_idx]))
                        rsp_n = R_W'(RSP__NOSTOCK);
                    else begin
                        it_we     = 1'b1;
                        it_wstock = item_stock[it_hit_idx] - S_W'(i_u);
                        rsp_n     = R_W'(RSP__DONE);
                    end
                end
                default: rsp_n = R_W'(RSP__INVALCMD);
            endcase
        end
`ifdef SHOP_IDLE_LOGOUT_EN
        else if (expire) begin
            state_n = S_CMD;
            user_n  = '0;
            vld_n   = 1'b1;
            rsp_n   = R_W'(RSP__TIMEOUT);
        end
`endif
        busy_n = (state_n != S_CMD);
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state     <= S_CMD;
            rdy_q     <= 1'b0;
            o_a       <= R_W'(RSP__CMD);
            o_vld     <= 1'b0;
            o_user    <= '0;
            o_busy    <= 1'b0;
            sel_q     <= '0;
            newname_q <= '0;
        end else begin
            state     <= state_n;
            rdy_q     <= i_rdy;
            o_a       <= rsp_n;
            o_vld     <= vld_n;
            o_user    <= user_n;
            o_busy    <= busy_n;
            sel_q     <= sel_n;
            newname_q <= newname_n;
        end
    end

    // Table storage; slot 0 of the user table is the admin loaded at reset.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < int'(MAX_USERS); i++) begin
                user_name[i] <= (i == 0) ? ADMIN_USERNAME : '0;
                user_pass[i] <= (i == 0) ? ADMIN_PASSWORD : '0;
                user_vld[i]  <= (i == 0);
            end
            for (int i = 0; i < int'(MAX_ITEMS); i++) begin
                item_name[i]  <= '0;
                item_stock[i] <= '0;
                item_vld[i]   <= 1'b0;
            end
        end else begin
            if (u_we) begin
                user_name[u_free_idx] <= newname_q;
                user_pass[u_free_idx] <= i_a;
                user_vld[u_free_idx]  <= 1'b1;
            end
            if (u_clr) user_vld[u_cidx] <= 1'b0;
            if (it_we) begin
                item_name[it_idx]  <= i_a;
                item_stock[it_idx] <= it_wstock;
                item_vld[it_idx]   <= 1'b1;
            end
            if (it_clr) begin
                item_name[it_idx]  <= '0;
                item_stock[it_idx] <= '0;
                item_vld[it_idx]   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_shop_ctrl_v.sv
// Directed bench for shop_ctrl_v: vector table for the command flow plus hand-written
// sequences for held strobe, asynchronous reset and idle logout.
module tb_shop_ctrl_v;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_rdy;
    logic [3:0]  i_u;
    logic [55:0] i_a;
    logic [71:0] o_a;
    logic        o_vld;
    logic [3:0]  o_user;
    logic        o_busy;

    int checks = 0;
    int errors = 0;

    localparam logic [71:0] R_CMDQ  = 72'("Cmd?");
    localparam logic [71:0] R_UNAME = 72'("Username?");
    localparam logic [71:0] R_PASS  = 72'("Password?");
    localparam logic [71:0] R_ITEM  = 72'("Item?");
    localparam logic [71:0] R_WEL   = 72'("Welcome");
    localparam logic [71:0] R_BYE   = 72'("Bye");
    localparam logic [71:0] R_DONE  = 72'("Done");
    localparam logic [71:0] R_FULL  = 72'("Full");
    localparam logic [71:0] R_EXIST = 72'("Exists");
    localparam logic [71:0] R_NOST  = 72'("NoStock");
    localparam logic [71:0] R_ICMD  = 72'("InvalCmd");
    localparam logic [71:0] R_PERM  = 72'("InvalPerm");
    localparam logic [71:0] R_IUSR  = 72'("InvalUsr");
    localparam logic [71:0] R_IPWD  = 72'("InvalPwd");
    localparam logic [71:0] R_IITEM = 72'("InvalItem");
    localparam logic [71:0] R_TMO   = 72'("Timeout");

    typedef struct {
        logic [55:0] tok;
        logic [3:0]  qty;
        logic [71:0] rsp;
        logic [3:0]  usr;
    } vec_t;

    vec_t vecs[$];

    shop_ctrl_v #(.STOCK_NUM_BITS(4), .IDLE_CYCLES(20)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_rdy(i_rdy), .i_u(i_u), .i_a(i_a),
        .o_a(o_a), .o_vld(o_vld), .o_user(o_user), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", nm, got, exp);
        end
    endtask

    function automatic logic exp_busy(input logic [71:0] r);
        return (r == R_UNAME) || (r == R_PASS) || (r == R_ITEM);
    endfunction

    task automatic add(input logic [55:0] t, input logic [3:0] q, input logic [71:0] r, input logic [3:0] u);
        vec_t v;
        v.tok = t; v.qty = q; v.rsp = r; v.usr = u;
        vecs.push_back(v);
    endtask

    // One token: response and pulse at the edge after the strobe, pulse gone one edge later.
    task automatic apply(input string nm, input logic [55:0] t, input logic [3:0] q,
                         input logic [71:0] r, input logic [3:0] u);
        @(negedge clk);
        i_a = t; i_u = q; i_rdy = 1'b1;
        @(posedge clk); #1;
        check({nm, " o_a"}, o_a, r);
        check({nm, " vld"}, 72'(o_vld), 72'd1);
        check({nm, " user"}, 72'(o_user), 72'(u));
        check({nm, " busy"}, 72'(o_busy), 72'(exp_busy(r)));
        @(negedge clk);
        i_rdy = 1'b0;
        @(posedge clk); #1;
        check({nm, " vld_clr"}, 72'(o_vld), 72'd0);
        check({nm, " hold"}, o_a, r);
    endtask

    initial begin
        int pulses;
        int waited;
        logic seen;

        i_reset = 1'b0; i_rdy = 1'b0; i_u = '0; i_a = '0;
        #12;
        check("reset o_a", o_a, R_CMDQ);
        check("reset vld", 72'(o_vld), 72'd0);
        check("reset user", 72'(o_user), 72'd0);
        check("reset busy", 72'(o_busy), 72'd0);
        @(negedge clk); i_reset = 1'b1;
        @(posedge clk); #1;
        check("post-reset o_a", o_a, R_CMDQ);

        add(56'("sdfsdf"),  4'd0,  R_ICMD,  4'h0);
        add(56'("AddItem"), 4'd0,  R_PERM,  4'h0);
        add(56'("Logout"),  4'd0,  R_PERM,  4'h0);
        add(56'("Login"),   4'd0,  R_UNAME, 4'h0);
        add(56'("Adm"),     4'd0,  R_PASS,  4'h0);
        add(56'("123"),     4'd0,  R_WEL,   4'h8);
        add(56'("Login"),   4'd0,  R_PERM,  4'h8);
        add(56'("AddItem"), 4'd0,  R_ITEM,  4'h8);
        add(56'("Pen"),     4'd15, R_DONE,  4'h8);
        add(56'("AddItem"), 4'd0,  R_ITEM,  4'h8);
        add(56'("Pen"),     4'd15, R_DONE,  4'h8);
        add(56'("Buy"),     4'd0,  R_ITEM,  4'h8);
        add(56'("Pen"),     4'd0,  R_NOST,  4'h8);
        add(56'("Buy"),     4'd0,  R_ITEM,  4'h8);
        add(56'("Pen"),     4'd5,  R_DONE,  4'h8);
        add(56'("Buy"),     4'd0,  R_ITEM,  4'h8);
        add(56'("Pen"),     4'd11, R_NOST,  4'h8);
        add(56'("Buy"),     4'd0,  R_ITEM,  4'h8);
        add(56'("Pen"),     4'd10, R_DONE,  4'h8);
        add(56'("Buy"),     4'd0,  R_ITEM,  4'h8);
        add(56'("Pen"),     4'd1,  R_NOST,  4'h8);
        add(56'("Buy"),     4'd0,  R_ITEM,  4'h8);
        add(56'("Cup"),     4'd1,  R_IITEM, 4'h8);
        add(56'("AddUsr"),  4'd0,  R_UNAME, 4'h8);
        add(56'("Bob"),     4'd0,  R_PASS,  4'h8);
        add(56'("pw"),      4'd0,  R_DONE,  4'h8);
        add(56'("AddUsr"),  4'd0,  R_UNAME, 4'h8);
        add(56'("Bob"),     4'd0,  R_EXIST, 4'h8);
        add(56'("AddUsr"),  4'd0,  R_UNAME, 4'h8);
        add(56'("Al"),      4'd0,  R_PASS,  4'h8);
        add(56'("1"),       4'd0,  R_DONE,  4'h8);
        add(56'("AddUsr"),  4'd0,  R_UNAME, 4'h8);
        add(56'("Cy"),      4'd0,  R_PASS,  4'h8);
        add(56'("2"),       4'd0,  R_DONE,  4'h8);
        add(56'("AddUsr"),  4'd0,  R_UNAME, 4'h8);
        add(56'("Di"),      4'd0,  R_PASS,  4'h8);
        add(56'("3"),       4'd0,  R_DONE,  4'h8);
        add(56'("AddUsr"),  4'd0,  R_FULL,  4'h8);
        add(56'("DelUsr"),  4'd0,  R_UNAME, 4'h8);
        add(56'("Adm"),     4'd0,  R_PERM,  4'h8);
        add(56'("DelUsr"),  4'd0,  R_UNAME, 4'h8);
        add(56'("Cy"),      4'd0,  R_DONE,  4'h8);
        add(56'("DelUsr"),  4'd0,  R_UNAME, 4'h8);
        add(56'("Cy"),      4'd0,  R_IUSR,  4'h8);
        add(56'("DelItem"), 4'd0,  R_ITEM,  4'h8);
        add(56'("Pen"),     4'd0,  R_DONE,  4'h8);
        add(56'("DelItem"), 4'd0,  R_ITEM,  4'h8);
        add(56'("Pen"),     4'd0,  R_IITEM, 4'h8);
        add(56'("Logout"),  4'd0,  R_BYE,   4'h0);
        add(56'("Login"),   4'd0,  R_UNAME, 4'h0);
        add(56'("Bob"),     4'd0,  R_PASS,  4'h0);
        add(56'("pw"),      4'd0,  R_WEL,   4'h9);
        add(56'("AddItem"), 4'd0,  R_PERM,  4'h9);
        add(56'("Buy"),     4'd0,  R_ITEM,  4'h9);
        add(56'("Cup"),     4'd1,  R_IITEM, 4'h9);
        add(56'("Logout"),  4'd0,  R_BYE,   4'h0);
        add(56'("Login"),   4'd0,  R_UNAME, 4'h0);
        add(56'("Bob"),     4'd0,  R_PASS,  4'h0);
        add(56'("bad"),     4'd0,  R_IPWD,  4'h0);
        add(56'("Login"),   4'd0,  R_UNAME, 4'h0);
        add(56'("Zed"),     4'd0,  R_IUSR,  4'h0);

        for (int i = 0; i < vecs.size(); i++)
            apply($sformatf("vec%0d", i), vecs[i].tok, vecs[i].qty, vecs[i].rsp, vecs[i].usr);

        // Held-high strobe yields exactly one token.
        @(negedge clk);
        i_a = 56'("Login"); i_u = '0; i_rdy = 1'b1;
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (o_vld) pulses++;
        end
        check("held pulses", 72'(pulses), 72'd1);
        check("held o_a", o_a, R_UNAME);
        @(negedge clk); i_rdy = 1'b0;
        apply("held next", 56'("Zed"), 4'd0, R_IUSR, 4'h0);

        // Asynchronous reset while waiting for a password.
        apply("ar login", 56'("Login"), 4'd0, R_UNAME, 4'h0);
        apply("ar name", 56'("Adm"), 4'd0, R_PASS, 4'h0);
        #2 i_reset = 1'b0;
        #1;
        check("ar o_a", o_a, R_CMDQ);
        check("ar busy", 72'(o_busy), 72'd0);
        check("ar user", 72'(o_user), 72'd0);
        check("ar vld", 72'(o_vld), 72'd0);
        @(negedge clk); i_reset = 1'b1;
        apply("ar login2", 56'("Login"), 4'd0, R_UNAME, 4'h0);
        apply("ar bob gone", 56'("Bob"), 4'd0, R_IUSR, 4'h0);
        apply("ar login3", 56'("Login"), 4'd0, R_UNAME, 4'h0);
        apply("ar adm", 56'("Adm"), 4'd0, R_PASS, 4'h0);
        apply("ar pwd", 56'("123"), 4'd0, R_WEL, 4'h8);

`ifdef SHOP_IDLE_LOGOUT_EN
        waited = 0; seen = 1'b0;
        while (!seen && waited < 60) begin
            @(posedge clk); #1;
            waited++;
            if (o_vld) seen = 1'b1;
        end
        check("tmo seen", 72'(seen), 72'd1);
        check("tmo o_a", o_a, R_TMO);
        check("tmo user", 72'(o_user), 72'd0);
        check("tmo window", 72'(waited >= 17 && waited <= 21), 72'd1);
        apply("tmo after", 56'("Logout"), 4'd0, R_PERM, 4'h0);
`else
        pulses = 0; waited = 0; seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (o_vld) pulses++;
        end
        check("no tmo pulses", 72'(pulses), 72'd0);
        check("no tmo user", 72'(o_user), 72'h8);
        apply("no tmo logout", 56'("Logout"), 4'd0, R_BYE, 4'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
